// File: rtl/lsb_ring.sv
// Load/store buffer: circular queue of memory ops waiting on operands and (for
// stores) ROB commit, issuing in program order through one registered slot.
module lsb_ring #(
  parameter int DEPTH  = 16,
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      disp_valid,
  input  logic [OP_W-1:0]           disp_op,
  input  logic                      disp_is_store,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [ROB_W-1:0]          disp_rob_id,
  input  logic                      disp_rs1_rdy,
  input  logic                      disp_rs2_rdy,
  input  logic [DATA_W-1:0]         disp_rs1_val,
  input  logic [DATA_W-1:0]         disp_rs2_val,
  input  logic [ROB_W-1:0]          disp_rs1_tag,
  input  logic [ROB_W-1:0]          disp_rs2_tag,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      cdb_valid,
  input  logic [ROB_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]         cdb_value,
  input  logic                      commit_valid,
  input  logic [ROB_W-1:0]          commit_rob_id,
  output logic                      exe_valid,
  input  logic                      exe_ready,
  output logic [OP_W-1:0]           exe_op,
  output logic                      exe_is_store,
  output logic [DATA_W-1:0]         exe_pc,
  output logic [DATA_W-1:0]         exe_rs1,
  output logic [DATA_W-1:0]         exe_rs2,
  output logic [DATA_W-1:0]         exe_imm,
  output logic [ROB_W-1:0]          exe_rob_id
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;

  logic [OP_W-1:0]   op_mem      [DEPTH];
  logic [DATA_W-1:0] pc_mem      [DEPTH];
  logic [DATA_W-1:0] imm_mem     [DEPTH];
  logic [ROB_W-1:0]  rob_mem     [DEPTH];
  logic [DATA_W-1:0] rs1_val_mem [DEPTH];
  logic [DATA_W-1:0] rs2_val_mem [DEPTH];
  logic [ROB_W-1:0]  rs1_tag_mem [DEPTH];
  logic [ROB_W-1:0]  rs2_tag_mem [DEPTH];
  logic [DEPTH-1:0]  is_store_reg, rs1_rdy_reg, rs2_rdy_reg, committed_reg;

  logic              exe_valid_reg, exe_is_store_reg;
  logic [OP_W-1:0]   exe_op_reg;
  logic [DATA_W-1:0] exe_pc_reg, exe_rs1_reg, exe_rs2_reg, exe_imm_reg;
  logic [ROB_W-1:0]  exe_rob_id_reg;

  logic [DEPTH-1:0] occ, rs1_hit, rs2_hit, commit_hit;

  // Per-entry occupancy and CAM matches against the CDB and commit port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PW-1:0] offset;
    assign offset         = PW'(gi) - head_reg;
    assign occ[gi]        = ({1'b0, offset} < count_reg);
    assign rs1_hit[gi]    = cdb_valid && occ[gi] && !rs1_rdy_reg[gi] && (rs1_tag_mem[gi] == cdb_tag);
    assign rs2_hit[gi]    = cdb_valid && occ[gi] && !rs2_rdy_reg[gi] && (rs2_tag_mem[gi] == cdb_tag);
    assign commit_hit[gi] = commit_valid && occ[gi] && is_store_reg[gi] && (rob_mem[gi] == commit_rob_id);
  end

  // Length of the run of committed stores starting at head; survives a flush.
  logic [CW-1:0] pref_len;
  logic [PW-1:0] pref_idx;
  logic          pref_stop;
  always_comb begin
    pref_len  = '0;
    pref_idx  = '0;
    pref_stop = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pref_idx = head_reg + PW'(i);
      if (!pref_stop && (CW'(i) < count_reg) && committed_reg[pref_idx])
        pref_len = pref_len + CW'(1);
      else
        pref_stop = 1'b1;
    end
  end

  logic head_ok, slot_free, do_pop, do_push;
  logic d_rs1_rdy, d_rs2_rdy;
  logic [DATA_W-1:0] d_rs1_val, d_rs2_val;

  assign full      = (count_reg == CW'(DEPTH));
  assign head_ok   = (count_reg != '0) && rs1_rdy_reg[head_reg] && rs2_rdy_reg[head_reg] &&
                     (!is_store_reg[head_reg] || committed_reg[head_reg]);
  assign slot_free = !exe_valid_reg || exe_ready;
  assign do_pop    = !flush && head_ok && slot_free;
  assign do_push   = !flush && disp_valid && !full;

  assign d_rs1_rdy = disp_rs1_rdy || (cdb_valid && (cdb_tag == disp_rs1_tag));
  assign d_rs2_rdy = disp_rs2_rdy || (cdb_valid && (cdb_tag == disp_rs2_tag));
  assign d_rs1_val = disp_rs1_rdy ? disp_rs1_val : cdb_value;
  assign d_rs2_val = disp_rs2_rdy ? disp_rs2_val : cdb_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      rs1_rdy_reg   <= '0;
      rs2_rdy_reg   <= '0;
      committed_reg <= '0;
      exe_valid_reg <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        tail_reg  <= head_reg + pref_len[PW-1:0];
        count_reg <= pref_len;
        // Only a committed store may survive in the slot, and not once taken.
        if (exe_valid_reg && (exe_ready || !exe_is_store_reg))
          exe_valid_reg <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rs1_hit[i]) begin
            rs1_rdy_reg[i] <= 1'b1;
            rs1_val_mem[i] <= cdb_value;
          end
          if (rs2_hit[i]) begin
            rs2_rdy_reg[i] <= 1'b1;
            rs2_val_mem[i] <= cdb_value;
          end
          if (commit_hit[i])
            committed_reg[i] <= 1'b1;
        end

        if (do_push) begin
          op_mem[tail_reg]        <= disp_op;
          pc_mem[tail_reg]        <= disp_pc;
          imm_mem[tail_reg]       <= disp_imm;
          rob_mem[tail_reg]       <= disp_rob_id;
          is_store_reg[tail_reg]  <= disp_is_store;
          rs1_rdy_reg[tail_reg]   <= d_rs1_rdy;
          rs2_rdy_reg[tail_reg]   <= d_rs2_rdy;
          rs1_val_mem[tail_reg]   <= d_rs1_val;
          rs2_val_mem[tail_reg]   <= d_rs2_val;
          rs1_tag_mem[tail_reg]   <= disp_rs1_tag;
          rs2_tag_mem[tail_reg]   <= disp_rs2_tag;
          committed_reg[tail_reg] <= 1'b0;
          tail_reg                <= tail_reg + PW'(1);
        end

        if (do_pop) begin
          head_reg         <= head_reg + PW'(1);
          exe_valid_reg    <= 1'b1;
          exe_op_reg       <= op_mem[head_reg];
          exe_is_store_reg <= is_store_reg[head_reg];
          exe_pc_reg       <= pc_mem[head_reg];
          exe_imm_reg      <= imm_mem[head_reg];
          exe_rs1_reg      <= rs1_val_mem[head_reg];
          exe_rs2_reg      <= rs2_val_mem[head_reg];
          exe_rob_id_reg   <= rob_mem[head_reg];
        end else if (exe_ready) begin
          exe_valid_reg <= 1'b0;
        end

        if (do_push && !do_pop)
          count_reg <= count_reg + CW'(1);
        else if (!do_push && do_pop)
          count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign count        = count_reg;
  assign exe_valid    = exe_valid_reg;
  assign exe_op       = exe_op_reg;
  assign exe_is_store = exe_is_store_reg;
  assign exe_pc       = exe_pc_reg;
  assign exe_rs1      = exe_rs1_reg;
  assign exe_rs2      = exe_rs2_reg;
  assign exe_imm      = exe_imm_reg;
  assign exe_rob_id   = exe_rob_id_reg;
endmodule

// File: tb/tb_lsb_ring.sv
// Directed bench for lsb_ring (DEPTH=4): issue timing, CDB wakeup, store commit,
// wrap-around, flush and stall/reset behaviour.
module tb_lsb_ring;
  localparam int DEPTH = 4, ROB_W = 4, DATA_W = 32, OP_W = 6;

  logic clk, rst, rdy, flush;
  logic disp_valid, disp_is_store, disp_rs1_rdy, disp_rs2_rdy;
  logic [OP_W-1:0] disp_op;
  logic [DATA_W-1:0] disp_pc, disp_imm, disp_rs1_val, disp_rs2_val;
  logic [ROB_W-1:0] disp_rob_id, disp_rs1_tag, disp_rs2_tag;
  logic full;
  logic [$clog2(DEPTH):0] count;
  logic cdb_valid, commit_valid;
  logic [ROB_W-1:0] cdb_tag, commit_rob_id;
  logic [DATA_W-1:0] cdb_value;
  logic exe_valid, exe_ready, exe_is_store;
  logic [OP_W-1:0] exe_op;
  logic [DATA_W-1:0] exe_pc, exe_rs1, exe_rs2, exe_imm;
  logic [ROB_W-1:0] exe_rob_id;

  int total = 0;
  int passed = 0;
  int exp_ids [4] = '{9, 10, 11, 13};

  lsb_ring #(.DEPTH(DEPTH), .ROB_W(ROB_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_is_store(disp_is_store),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_rob_id(disp_rob_id),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_op(exe_op),
    .exe_is_store(exe_is_store), .exe_pc(exe_pc), .exe_rs1(exe_rs1),
    .exe_rs2(exe_rs2), .exe_imm(exe_imm), .exe_rob_id(exe_rob_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_disp(input logic st, input logic [3:0] rob,
                          input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                          input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    disp_valid    = 1'b1;
    disp_is_store = st;
    disp_op       = st ? 6'h23 : 6'h03;
    disp_rob_id   = rob;
    disp_pc       = 32'h1000 + {28'h0, rob};
    disp_imm      = 32'h4;
    disp_rs1_rdy  = r1; disp_rs1_val = v1; disp_rs1_tag = t1;
    disp_rs2_rdy  = r2; disp_rs2_val = v2; disp_rs2_tag = t2;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    disp_valid = 1'b0; disp_is_store = 1'b0; disp_op = '0; disp_pc = '0; disp_imm = '0;
    disp_rob_id = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
    disp_rs1_val = '0; disp_rs2_val = '0; disp_rs1_tag = '0; disp_rs2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    commit_valid = 1'b0; commit_rob_id = '0; exe_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_exe_valid", exe_valid, 0);
    check("reset_count", count, 0);
    check("reset_full", full, 0);

    // rdy low freezes the queue: dispatch must not land
    rdy = 1'b0;
    set_disp(0, 4'd0, 1, 32'h1, 4'd0, 1, 32'h2, 4'd0);
    step();
    disp_valid = 1'b0; rdy = 1'b1;
    check("rdy0_count", count, 0);
    check("rdy0_exe_valid", exe_valid, 0);

    // ready load issues the cycle after it is written
    set_disp(0, 4'd1, 1, 32'h100, 4'd0, 1, 32'h5, 4'd0);
    step();
    disp_valid = 1'b0;
    check("ld_count_after_disp", count, 1);
    check("ld_not_yet_valid", exe_valid, 0);
    step();
    check("ld_exe_valid", exe_valid, 1);
    check("ld_exe_rs1", exe_rs1, 32'h100);
    check("ld_exe_pc", exe_pc, 32'h1001);
    check("ld_count_back", count, 0);
    step();
    check("ld_accepted", exe_valid, 0);

    // store waits for commit
    set_disp(1, 4'd3, 1, 32'h20, 4'd0, 1, 32'h30, 4'd0);
    step();
    disp_valid = 1'b0;
    repeat (5) step();
    check("st_blocked_valid", exe_valid, 0);
    check("st_blocked_count", count, 1);
    commit_valid = 1'b1; commit_rob_id = 4'd3;
    step();
    commit_valid = 1'b0;
    step();
    check("st_issue_valid", exe_valid, 1);
    check("st_issue_is_store", exe_is_store, 1);
    check("st_issue_rob", exe_rob_id, 3);
    check("st_issue_rs2", exe_rs2, 32'h30);
    step();

    // same-cycle CDB capture at dispatch
    set_disp(0, 4'd2, 0, 32'h0, 4'd5, 1, 32'h7, 4'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'hABCD;
    step();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    step();
    check("cdb_disp_valid", exe_valid, 1);
    check("cdb_disp_rs1", exe_rs1, 32'hABCD);
    step();

    // later CDB wakes both operands of one entry
    set_disp(0, 4'd6, 0, 32'h0, 4'd6, 0, 32'h0, 4'd6);
    step();
    disp_valid = 1'b0;
    check("wake_wait_valid", exe_valid, 0);
    check("wake_wait_count", count, 1);
    cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'h77;
    step();
    cdb_valid = 1'b0;
    check("wake_no_same_cycle_issue", exe_valid, 0);
    step();
    check("wake_rs1", exe_rs1, 32'h77);
    check("wake_rs2", exe_rs2, 32'h77);
    step();

    // fill to DEPTH with blocked stores, then wrap
    for (int i = 0; i < 4; i++) begin
      set_disp(1, 4'(8 + i), 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
      step();
    end
    disp_valid = 1'b0;
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    set_disp(0, 4'd12, 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    step();
    disp_valid = 1'b0;
    check("full_disp_ignored", count, 4);
    commit_valid = 1'b1; commit_rob_id = 4'd8;
    step();
    commit_valid = 1'b0;
    step();
    check("pop_count", count, 3);
    check("pop_full", full, 0);
    check("pop_rob8", exe_rob_id, 8);
    set_disp(0, 4'd13, 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    commit_valid = 1'b1; commit_rob_id = 4'd9;
    step();
    disp_valid = 1'b0;
    check("wrap_count", count, 4);
    check("wrap_slot_empty", exe_valid, 0);
    commit_rob_id = 4'd10;
    step();
    check("wrap_order_0", exe_rob_id, exp_ids[0]);
    commit_rob_id = 4'd11;
    step();
    check("wrap_order_1", exe_rob_id, exp_ids[1]);
    commit_valid = 1'b0;
    step();
    check("wrap_order_2", exe_rob_id, exp_ids[2]);
    step();
    check("wrap_order_3", exe_rob_id, exp_ids[3]);
    check("wrap_last_is_load", exe_is_store, 0);
    step();
    check("wrap_drained_valid", exe_valid, 0);
    check("wrap_drained_count", count, 0);

    // flush keeps only the committed store prefix
    set_disp(1, 4'd1, 0, 32'h0, 4'd7, 1, 32'h0, 4'd0);
    step();
    set_disp(0, 4'd2, 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    step();
    set_disp(1, 4'd3, 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    commit_valid = 1'b1; commit_rob_id = 4'd1;
    step();
    commit_valid = 1'b0;
    check("pre_flush_count", count, 3);
    set_disp(0, 4'd14, 1, 32'h0, 4'd0, 1, 32'h0, 4'd0);
    flush = 1'b1;
    step();
    flush = 1'b0; disp_valid = 1'b0;
    check("flush_count", count, 1);
    check("flush_exe_valid", exe_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h42;
    step();
    cdb_valid = 1'b0;
    step();
    check("flush_s1_valid", exe_valid, 1);
    check("flush_s1_rob", exe_rob_id, 1);
    check("flush_s1_rs1", exe_rs1, 32'h42);
    step();
    check("flush_after_valid", exe_valid, 0);
    check("flush_after_count", count, 0);
    step();
    check("flush_no_l1", exe_valid, 0);

    // stall holds the slot; reset abandons it
    exe_ready = 1'b0;
    set_disp(0, 4'd4, 1, 32'h11, 4'd0, 1, 32'h0, 4'd0);
    step();
    set_disp(0, 4'd5, 1, 32'h22, 4'd0, 1, 32'h0, 4'd0);
    step();
    disp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", exe_valid, 1);
      check("stall_rob", exe_rob_id, 4);
      check("stall_rs1", exe_rs1, 32'h11);
      check("stall_count", count, 1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_stall_valid", exe_valid, 0);
    check("rst_stall_count", count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
